// File: rtl/bitwise_logic_unit_seq.sv
// bitwise_logic_unit_seq: applies AND/OR/XOR/NAND to two WIDTH-bit operands,
// producing CHUNK result bits per clock, LSB chunk first.
// Optional feature: define LOGIC_UNIT_ZERO_FLAG_EN to add the registered
// 'zero' output (result == 0). WIDTH must be an integer multiple of CHUNK.
module bitwise_logic_unit_seq #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Index counter is at least one bit so the single-chunk case still builds.
  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] full_val;
  logic [WIDTH-1:0] result_upd;

  // Full-width operation on the captured operands; only the current chunk is used.
  always_comb begin
    full_val = '0;
    case (op_reg)
      2'b00:   full_val = a_reg & b_reg;
      2'b01:   full_val = a_reg | b_reg;
      2'b10:   full_val = a_reg ^ b_reg;
      default: full_val = ~(a_reg & b_reg);
    endcase
  end

  // Result with the chunk selected by idx replaced; every other chunk kept.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
      assign result_upd[gi*CHUNK +: CHUNK] = (idx == IDX_W'(gi))
                                           ? full_val[gi*CHUNK +: CHUNK]
                                           : result[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // Control FSM with registered outputs; reset wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      idx    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= 2'b00;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
      zero   <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Capture operands so later input changes cannot disturb the run.
            a_reg  <= a;
            b_reg  <= b;
            op_reg <= op;
            result <= '0;
            idx    <= '0;
            state  <= RUN;
            busy   <= 1'b1;
            done   <= 1'b0;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
            zero   <= 1'b1;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          result <= result_upd;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
          zero   <= (result_upd == '0);
`endif
          if (idx == LAST_IDX) begin
            // Last chunk written: idx is left as-is so it never wraps.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_logic_unit_seq.sv
// Directed bench for bitwise_logic_unit_seq: default 8/2 instance plus
// 16/4 and 8/8 instances. Zero flag is checked when LOGIC_UNIT_ZERO_FLAG_EN is set.
`timescale 1ns/1ps
module tb_bitwise_logic_unit_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance (WIDTH=8, CHUNK=2)
  logic       rst = 1'b1, start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] a = '0, b = '0, result;
  logic       busy, done;
  // WIDTH=16, CHUNK=4
  logic        start16 = 1'b0;
  logic [1:0]  op16 = 2'b00;
  logic [15:0] a16 = '0, b16 = '0, result16;
  logic        busy16, done16;
  // WIDTH=8, CHUNK=8
  logic       start88 = 1'b0;
  logic [1:0] op88 = 2'b00;
  logic [7:0] a88 = '0, b88 = '0, result88;
  logic       busy88, done88;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic zero, zero16, zero88;
`endif

  bitwise_logic_unit_seq #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  bitwise_logic_unit_seq #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .result(result16)
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    , .zero(zero16)
`endif
  );

  bitwise_logic_unit_seq #(.WIDTH(8), .CHUNK(8)) dut88 (
    .clk(clk), .rst(rst), .start(start88), .op(op88), .a(a88), .b(b88),
    .busy(busy88), .done(done88), .result(result88)
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    , .zero(zero88)
`endif
  );

  // Drive one start pulse on the 8/2 instance and observe until done (bounded).
  // dc = cycle index (1 = cycle after accept edge) where done was seen, 0 if never.
  task automatic run8(input logic [1:0] o, input logic [7:0] av, input logic [7:0] bv,
                      output int bc, output int dc, output logic [7:0] res, output logic z);
    @(negedge clk); start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk); start = 1'b0;
    bc = 0; dc = 0; res = '0; z = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) bc++;
      if (done) begin
        dc = i; res = result;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
        z = zero;
`endif
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; op = 2'b01;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h want 00", result); end
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
`endif
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    $display("reset: busy=%b done=%b result=%h", busy, done, result);
  endtask

  task automatic test_basic();
    int bc, dc; logic [7:0] res; logic z;
    run8(2'b00, 8'hFF, 8'h00, bc, dc, res, z);
    $display("basic AND FF,00: busy_cycles=%0d done_cycle=%0d result=%h", bc, dc, res);
    checks++; if (bc !== 4) begin errors++; $display("FAIL basic_busy_cycles got %0d want 4", bc); end
    checks++; if (dc !== 5) begin errors++; $display("FAIL basic_done_cycle got %0d want 5", dc); end
    checks++; if (res !== 8'h00) begin errors++; $display("FAIL basic_result got %h want 00", res); end
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL basic_zero got %b want 1", z); end
`endif
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
  endtask

  task automatic test_ops();
    logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [7:0] av  [4] = '{8'hFF, 8'h0F, 8'hFF, 8'hFF};
    logic [7:0] bv  [4] = '{8'hA9, 8'hF0, 8'hA9, 8'hFF};
    logic [7:0] ex  [4] = '{8'hA9, 8'hFF, 8'h56, 8'h00};
    int bc, dc; logic [7:0] res; logic z;
    for (int k = 0; k < 4; k++) begin
      run8(ops[k], av[k], bv[k], bc, dc, res, z);
      $display("op=%b a=%h b=%h: done_cycle=%0d result=%h", ops[k], av[k], bv[k], dc, res);
      checks++; if (res !== ex[k]) begin errors++; $display("FAIL op%0d_result got %h want %h", k, res, ex[k]); end
      checks++; if (dc !== 5) begin errors++; $display("FAIL op%0d_done_cycle got %0d want 5", k, dc); end
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
      checks++; if (z !== (ex[k] == 8'h00)) begin errors++; $display("FAIL op%0d_zero got %b want %b", k, z, ex[k] == 8'h00); end
`endif
      // Result must hold once back in IDLE.
      repeat (2) @(negedge clk);
      checks++; if (result !== ex[k]) begin errors++; $display("FAIL op%0d_hold got %h want %h", k, result, ex[k]); end
    end
  endtask

  task automatic test_back_to_back();
    int dc = 0, dc2 = 0;
    @(negedge clk); start = 1'b1; op = 2'b00; a = 8'hF0; b = 8'h3C;   // expect 30
    @(negedge clk); op = 2'b01; a = 8'h55; b = 8'hAA;                  // ignored, start held
    for (int i = 1; i <= 20; i++) begin
      if (done) begin dc = i; break; end
      @(negedge clk);
    end
    $display("held start: done_cycle=%0d result=%h", dc, result);
    checks++; if (dc !== 5) begin errors++; $display("FAIL hold_done_cycle got %0d want 5", dc); end
    checks++; if (result !== 8'h30) begin errors++; $display("FAIL hold_result got %h want 30", result); end
    // start still high in DONE: second operation accepted with no idle cycle.
    op = 2'b10; a = 8'h0F; b = 8'hFF;                                  // expect F0
    @(negedge clk); start = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got done=%b busy=%b want done=0 busy=1", done, busy); end
    for (int j = 1; j <= 20; j++) begin
      if (done) begin dc2 = j; break; end
      @(negedge clk);
    end
    $display("back-to-back: done_cycle=%0d result=%h", dc2, result);
    checks++; if (dc2 !== 5) begin errors++; $display("FAIL b2b_done_cycle got %0d want 5", dc2); end
    checks++; if (result !== 8'hF0) begin errors++; $display("FAIL b2b_result got %h want F0", result); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int seen = 0;
    @(negedge clk); start = 1'b1; op = 2'b01; a = 8'hFF; b = 8'hFF;
    @(negedge clk); start = 1'b0;      // RUN cycle 1
    @(negedge clk);                    // RUN cycle 2: chunk 0 written
    checks++; if (result !== 8'h03) begin errors++; $display("FAIL abort_partial got %h want 03", result); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    $display("abort: busy=%b done=%b result=%h", busy, done, result);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL abort_result got %h want 00", result); end
    for (int i = 0; i < 8; i++) begin
      if (done) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
  endtask

  task automatic test_widths();
    int bc = 0, dc = 0;
    @(negedge clk); start16 = 1'b1; op16 = 2'b00; a16 = 16'h1234; b16 = 16'hFFFF;
    @(negedge clk); start16 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (busy16) bc++;
      if (done16) begin dc = i; break; end
      @(negedge clk);
    end
    $display("w16c4 AND 1234,FFFF: busy_cycles=%0d done_cycle=%0d result=%h", bc, dc, result16);
    checks++; if (bc !== 4) begin errors++; $display("FAIL w16_busy got %0d want 4", bc); end
    checks++; if (dc !== 5) begin errors++; $display("FAIL w16_done_cycle got %0d want 5", dc); end
    checks++; if (result16 !== 16'h1234) begin errors++; $display("FAIL w16_result got %h want 1234", result16); end
    bc = 0; dc = 0;
    @(negedge clk); start88 = 1'b1; op88 = 2'b10; a88 = 8'hC3; b88 = 8'h5A;
    @(negedge clk); start88 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (busy88) bc++;
      if (done88) begin dc = i; break; end
      @(negedge clk);
    end
    $display("w8c8 XOR C3,5A: busy_cycles=%0d done_cycle=%0d result=%h", bc, dc, result88);
    checks++; if (bc !== 1) begin errors++; $display("FAIL w88_busy got %0d want 1", bc); end
    checks++; if (dc !== 2) begin errors++; $display("FAIL w88_done_cycle got %0d want 2", dc); end
    checks++; if (result88 !== 8'h99) begin errors++; $display("FAIL w88_result got %h want 99", result88); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ops();
    test_back_to_back();
    test_abort();
    test_widths();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
